// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between 8 requesters and the round-robin arbiter.
// "release" is a reserved word in SystemVerilog, so the owner's done strobe is owner_release.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       owner_release;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req, owner_release,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, owner_release,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter with index + one-hot grant and optional hold limit.
// Request to grant in one cycle; every grant end is followed by at least one idle cycle.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst,
  rr_decode_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic       pick_vld;
  logic [2:0] pick_idx;
  logic       own_req;
  logic       hold_hit;
  logic       grant_end;

  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    dec3to8 = 8'b1 << idx;
  endfunction

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[ptr_q + 3'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 3'(i);
      end
    end
  end

  assign own_req   = bus.req[idx_q];
  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == 8'(MAX_HOLD));
  assign grant_end = bus.owner_release || !own_req || hold_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld)  state_d = BUSY;
      BUSY:    if (grant_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d      = pick_idx;
          hold_cnt_d = 8'd1;
        end
      end
      BUSY: begin
        if (grant_end) begin
          ptr_d     = idx_q + 3'd1;
          timeout_d = hold_hit && own_req && !bus.owner_release;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
    valid_d = (state_d == BUSY);
    grant_d = valid_d ? dec3to8(idx_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 3'd0;
      idx_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      grant_q    <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus random traffic against an owner/pointer model.
module tb_rr_decode_arbiter;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_decode_arbiter_if bus();

  rr_decode_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who owns the resource (-1 = nobody), last owner, rotation start, cycles held.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input bit rel, input bit rs);
    bit drop, lim;
    if (rs) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 8 && m_owner < 0; k++)
          if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_held = 1;
        end
      end else begin
        drop = !r[m_owner];
        lim  = (MAXH != 0) && (m_held >= MAXH);
        if (rel || drop || lim) begin
          m_to    = lim && !rel && !drop;
          m_ptr   = (m_owner + 1) % 8;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("grant",     32'(bus.grant),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("grant_idx", 32'(bus.grant_idx),   32'(m_last));
    check("valid",     32'(bus.grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("timeout",   32'(bus.timeout),     32'(m_to));
    check("onehot",    32'($countones(bus.grant) <= 1), 32'd1);
  endtask

  task automatic step(input logic [7:0] r, input bit rel);
    bus.req           = r;
    bus.owner_release = rel;
    @(posedge clk);
    model_step(r, rel, rst);
    #1;
    compare_all();
    if (r == 8'h00) check("no_grant_after_idle_req", 32'(bus.grant_valid), 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst = 1'b1;
    step(r, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bus.req           = 8'h00;
    bus.owner_release = 1'b0;

    do_reset(8'h00);
    check("rst_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);

    // Single requester, released after one cycle.
    step(8'h04, 1'b0);
    check("s1_grant", 32'(bus.grant), 32'h04);
    check("s1_idx",   32'(bus.grant_idx), 32'd2);
    step(8'h04, 1'b1);
    check("s1_rel_grant", 32'(bus.grant), 32'd0);
    check("s1_rel_to",    32'(bus.timeout), 32'd0);

    // All requesting, release every grant: strict rotation 0..7,0.
    do_reset(8'h00);
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0);
      check("rr_idx", 32'(bus.grant_idx), 32'(g % 8));
      check("rr_vld", 32'(bus.grant_valid), 32'd1);
      step(8'hFF, 1'b1);
      check("rr_bubble", 32'(bus.grant_valid), 32'd0);
    end

    // Hold limit reached by a lone requester 7.
    do_reset(8'h00);
    for (int k = 0; k < 4; k++) begin
      step(8'h80, 1'b0);
      check("hold_vld", 32'(bus.grant_valid), 32'd1);
      check("hold_to",  32'(bus.timeout), 32'd0);
    end
    step(8'h80, 1'b0);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    check("to_grant", 32'(bus.grant), 32'd0);
    step(8'h80, 1'b0);
    check("regrant_idx", 32'(bus.grant_idx), 32'd7);
    check("regrant_vld", 32'(bus.grant_valid), 32'd1);
    check("to_clear",    32'(bus.timeout), 32'd0);

    // Release wins over the hold limit in the same cycle.
    do_reset(8'h00);
    for (int k = 0; k < 4; k++) step(8'h80, 1'b0);
    step(8'h80, 1'b1);
    check("rel_prio_to",  32'(bus.timeout), 32'd0);
    check("rel_prio_vld", 32'(bus.grant_valid), 32'd0);

    // Owner drops its request; pointer moves past it.
    do_reset(8'h00);
    step(8'h28, 1'b0);
    check("drop_owner", 32'(bus.grant_idx), 32'd3);
    step(8'h20, 1'b0);
    check("drop_end", 32'(bus.grant_valid), 32'd0);
    check("drop_to",  32'(bus.timeout), 32'd0);
    step(8'h28, 1'b0);
    check("drop_next", 32'(bus.grant_idx), 32'd5);

    // Reset while granted clears everything, pointer back to 0.
    do_reset(8'h28);
    check("midrst_grant", 32'(bus.grant), 32'd0);
    check("midrst_idx",   32'(bus.grant_idx), 32'd0);
    check("midrst_to",    32'(bus.timeout), 32'd0);
    step(8'h03, 1'b0);
    check("midrst_ptr", 32'(bus.grant_idx), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [7:0] r;
      bit         rel;
      r   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom & $urandom);
      rel = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) do_reset(r);
      else                            step(r, rel);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
